// File: rtl/clkdiv_sched.sv
// clkdiv_sched: programmable divide-by-N strobe scheduler.
//
// Emits a one-cycle `tick` every `cur_div` clocks while running. A new
// divisor/burst is taken over a valid/ready handshake and only ever takes
// effect on a period boundary (or when the scheduler goes idle), so tick
// spacing never glitches. A nonzero burst length stops the run after that
// many ticks and pulses `done`.
//
// Handshake: a configuration transfers on any rising clk edge where
// cfg_valid && cfg_ready are both high. cfg_ready is low only while one
// configuration is already held waiting for a period boundary.
//
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   en           level enable; rising edge starts a run, low stops it
//   cfg_valid    configuration offer (cfg_div, cfg_burst)
//   cfg_ready    configuration accept
//   cfg_div      requested divisor N (0 is rejected via cfg_err)
//   cfg_burst    ticks per run, 0 = free-run
//   tick         strobe, high one cycle per period
//   busy         scheduler is not idle
//   done         one-cycle pulse after a burst completes
//   cfg_err      one-cycle pulse after a cfg with cfg_div==0 was accepted
//   cur_div      divisor currently in force
//   tick_cnt     ticks emitted in the current run, saturating
//   dbg_state    raw FSM state for observation
module clkdiv_sched #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_burst,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic [W-1:0] tick_cnt,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] burst_q, burst_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic [W-1:0] pend_burst_q, pend_burst_d;
  logic [W-1:0] tick_cnt_q, tick_cnt_d;
  logic         en_q, en_d;
  logic         done_q, done_d;
  logic         cfg_err_q, cfg_err_d;

  logic         cfg_xfer;
  logic         cfg_ok;
  logic         tick_now;
  logic         last;
  logic [W-1:0] tick_cnt_inc;
  logic         burst_hit;

  // All outputs decode registered state only.
  assign tick      = (state_q != IDLE) && (cnt_q == '0);
  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q != PEND);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign cur_div   = div_q;
  assign tick_cnt  = tick_cnt_q;
  assign dbg_state = state_q;

  assign cfg_xfer     = cfg_valid && cfg_ready;
  assign cfg_ok       = cfg_xfer && (cfg_div != '0);
  assign tick_now     = tick;
  assign last         = (cnt_q == div_q - 1'b1);
  assign tick_cnt_inc = (tick_cnt_q == '1) ? tick_cnt_q : tick_cnt_q + 1'b1;
  // Compare against the count this tick produces, using the burst in force.
  assign burst_hit    = tick_now && (burst_q != '0) && (tick_cnt_inc == burst_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    burst_d      = burst_q;
    pend_div_d   = pend_div_q;
    pend_burst_d = pend_burst_q;
    tick_cnt_d   = tick_cnt_q;
    en_d         = en;
    done_d       = 1'b0;
    cfg_err_d    = cfg_xfer && (cfg_div == '0);

    if (state_q == IDLE) begin
      cnt_d = '0;
      // Applied on the same edge as a start, so the first period uses it.
      if (cfg_ok) begin
        div_d   = cfg_div;
        burst_d = cfg_burst;
      end
      if (en && !en_q) begin
        state_d    = RUN;
        tick_cnt_d = '0;
      end
    end else begin
      if (tick_now) begin
        tick_cnt_d = tick_cnt_inc;
      end
      if (!en || burst_hit) begin
        // Going idle: any held or freshly offered cfg lands now.
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = burst_hit;
        if (state_q == PEND) begin
          div_d   = pend_div_q;
          burst_d = pend_burst_q;
        end else if (cfg_ok) begin
          div_d   = cfg_div;
          burst_d = cfg_burst;
        end
      end else begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (state_q == PEND) begin
          if (last) begin
            div_d   = pend_div_q;
            burst_d = pend_burst_q;
            state_d = RUN;
          end
        end else if (cfg_ok) begin
          if (last) begin
            div_d   = cfg_div;
            burst_d = cfg_burst;
          end else begin
            pend_div_d   = cfg_div;
            pend_burst_d = cfg_burst;
            state_d      = PEND;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= W'(DEFAULT_DIV);
      burst_q      <= '0;
      pend_div_q   <= '0;
      pend_burst_q <= '0;
      tick_cnt_q   <= '0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      burst_q      <= burst_d;
      pend_div_q   <= pend_div_d;
      pend_burst_q <= pend_burst_d;
      tick_cnt_q   <= tick_cnt_d;
      en_q         <= en_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule
